// File: rtl/branch_target_table.sv
// Writable branch-target table: registered lookup with hit flag, forwarding write port, sequential clear.
// Define BTT_LEGACY_PRELOAD_EN to reset entries 0-8 to the legacy fixed targets.
module branch_target_table #(
    parameter int INDEX_W = 8,
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               lookup_req,
    input  logic [INDEX_W-1:0] lookup_index,
    output logic               lookup_valid,
    output logic               lookup_hit,
    output logic [DATA_W-1:0]  lookup_target,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [DATA_W-1:0]  wr_data,
    input  logic               clr_start,
    output logic               wr_ready,
    output logic               busy
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

`ifdef BTT_LEGACY_PRELOAD_EN
    localparam bit PRELOAD_OK = (DATA_W >= 8) && (DEPTH >= 9);
`else
    localparam bit PRELOAD_OK = 1'b0;
`endif

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t              state_q, next_state;
    logic [ADDR_W-1:0]   cnt_q;
    logic [DATA_W-1:0]   data_q [DEPTH];
    logic [DEPTH-1:0]    valid_q;
    logic [ADDR_W-1:0]   lk_addr, wr_addr;
    logic                wr_accept;
    logic                lk_hit;
    logic [DATA_W-1:0]   lk_target;

    function automatic logic [7:0] preload_val(input int i);
        case (i)
            0: return 8'h60;
            1: return 8'h48;
            2: return 8'h78;
            3: return 8'h72;
            4: return 8'h6A;
            5: return 8'h69;
            6: return 8'h5C;
            7: return 8'h7E;
            8: return 8'h7B;
            default: return 8'h00;
        endcase
    endfunction

    // Indices alias modulo DEPTH; the upper bits are deliberately discarded.
    generate
        if (INDEX_W > ADDR_W) begin : g_hi_bits
            logic unused_hi;
            assign unused_hi = ^{lookup_index[INDEX_W-1:ADDR_W], wr_index[INDEX_W-1:ADDR_W]};
        end
    endgenerate

    assign lk_addr   = lookup_index[ADDR_W-1:0];
    assign wr_addr   = wr_index[ADDR_W-1:0];
    assign busy      = (state_q == CLEAR);
    assign wr_ready  = ~busy;
    assign wr_accept = wr_en && (state_q == IDLE);

    always_comb begin
        next_state = state_q;
        case (state_q)
            IDLE:    if (clr_start) next_state = CLEAR;
            CLEAR:   if (cnt_q == LAST) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= next_state;
            if (state_q == IDLE)
                cnt_q <= '0;
            else
                cnt_q <= cnt_q + 1'b1;
        end
    end

    // Clearing forces a miss; an accepted same-address write wins over stored contents.
    always_comb begin
        lk_hit    = 1'b0;
        lk_target = '0;
        if (state_q == IDLE) begin
            if (wr_accept && (wr_addr == lk_addr)) begin
                lk_hit    = 1'b1;
                lk_target = wr_data;
            end else if (valid_q[lk_addr]) begin
                lk_hit    = 1'b1;
                lk_target = data_q[lk_addr];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i]  <= (PRELOAD_OK && (i < 9)) ? DATA_W'(preload_val(i)) : '0;
                valid_q[i] <= PRELOAD_OK && (i < 9);
            end
        end else if (state_q == CLEAR) begin
            data_q[cnt_q]  <= '0;
            valid_q[cnt_q] <= 1'b0;
        end else if (wr_accept) begin
            data_q[wr_addr]  <= wr_data;
            valid_q[wr_addr] <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lookup_valid  <= 1'b0;
            lookup_hit    <= 1'b0;
            lookup_target <= '0;
        end else begin
            lookup_valid <= lookup_req;
            if (lookup_req) begin
                lookup_hit    <= lk_hit;
                lookup_target <= lk_target;
            end
        end
    end

endmodule

// File: tb/tb_branch_target_table.sv
// Directed bench for branch_target_table: vector table plus clear / reset / throughput sequences.
module tb_branch_target_table;

    localparam int INDEX_W = 8;
    localparam int ADDR_W  = 4;
    localparam int DATA_W  = 8;
    localparam int DEPTH   = 16;

`ifdef BTT_LEGACY_PRELOAD_EN
    localparam bit PL = 1'b1;
`else
    localparam bit PL = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               lookup_req = 1'b0;
    logic [INDEX_W-1:0] lookup_index = '0;
    logic               lookup_valid;
    logic               lookup_hit;
    logic [DATA_W-1:0]  lookup_target;
    logic               wr_en = 1'b0;
    logic [INDEX_W-1:0] wr_index = '0;
    logic [DATA_W-1:0]  wr_data = '0;
    logic               clr_start = 1'b0;
    logic               wr_ready;
    logic               busy;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic       req;
        logic [7:0] idx;
        logic       we;
        logic [7:0] widx;
        logic [7:0] wdata;
        logic       clr;
        logic       ev;
        logic       eh;
        logic [7:0] et;
    } vec_t;

    vec_t       vecs [9];
    logic [7:0] md [DEPTH];
    logic       mv [DEPTH];

    always #5 clk = ~clk;

    branch_target_table #(.INDEX_W(INDEX_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .lookup_req(lookup_req), .lookup_index(lookup_index),
        .lookup_valid(lookup_valid), .lookup_hit(lookup_hit), .lookup_target(lookup_target),
        .wr_en(wr_en), .wr_index(wr_index), .wr_data(wr_data),
        .clr_start(clr_start), .wr_ready(wr_ready), .busy(busy)
    );

    function automatic logic [7:0] pl_val(input int i);
        case (i)
            0: return 8'h60;
            1: return 8'h48;
            2: return 8'h78;
            3: return 8'h72;
            4: return 8'h6A;
            5: return 8'h69;
            6: return 8'h5C;
            7: return 8'h7E;
            8: return 8'h7B;
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            mv[i] = PL && (i < 9);
            md[i] = mv[i] ? pl_val(i) : 8'h00;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        lookup_req   = v.req;
        lookup_index = v.idx;
        wr_en        = v.we;
        wr_index     = v.widx;
        wr_data      = v.wdata;
        clr_start    = v.clr;
    endtask

    task automatic idle_inputs();
        lookup_req = 1'b0;
        wr_en      = 1'b0;
        clr_start  = 1'b0;
    endtask

    task automatic write_entry(input logic [7:0] idx, input logic [7:0] d);
        idle_inputs();
        wr_en    = 1'b1;
        wr_index = idx;
        wr_data  = d;
        tick();
        wr_en = 1'b0;
        md[idx[3:0]] = d;
        mv[idx[3:0]] = 1'b1;
    endtask

    initial begin
        int  busy_cycles;
        int  guard;
        logic [3:0] a;

        // {req, idx, we, widx, wdata, clr, exp_valid, exp_hit, exp_target}
        vecs[0] = '{1'b1, 8'h07, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, PL,   PL ? 8'h7E : 8'h00};
        vecs[1] = '{1'b1, 8'h09, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00};
        vecs[2] = '{1'b0, 8'h00, 1'b1, 8'h05, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[3] = '{1'b1, 8'h15, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA5};
        vecs[4] = '{1'b1, 8'h02, 1'b1, 8'h02, 8'h3C, 1'b0, 1'b1, 1'b1, 8'h3C};
        vecs[5] = '{1'b1, 8'h02, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 8'h3C};
        vecs[6] = '{1'b1, 8'h08, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, PL,   PL ? 8'h7B : 8'h00};
        vecs[7] = '{1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, PL,   PL ? 8'h7B : 8'h00};
        vecs[8] = '{1'b1, 8'h22, 1'b1, 8'h12, 8'h11, 1'b0, 1'b1, 1'b1, 8'h11};

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_valid",  32'(lookup_valid),  32'd0);
        checkOutput("rst_hit",    32'(lookup_hit),    32'd0);
        checkOutput("rst_target", 32'(lookup_target), 32'd0);
        checkOutput("rst_busy",   32'(busy),          32'd0);
        checkOutput("rst_ready",  32'(wr_ready),      32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i]);
            tick();
            checkOutput($sformatf("vec%0d_valid", i),  32'(lookup_valid),  32'(vecs[i].ev));
            checkOutput($sformatf("vec%0d_hit", i),    32'(lookup_hit),    32'(vecs[i].eh));
            checkOutput($sformatf("vec%0d_target", i), 32'(lookup_target), 32'(vecs[i].et));
            checkOutput($sformatf("vec%0d_busy", i),   32'(busy),          32'd0);
        end

        // Write and clr_start together: write lands, then the clear wipes it.
        idle_inputs();
        clr_start = 1'b1;
        wr_en     = 1'b1;
        wr_index  = 8'h03;
        wr_data   = 8'h99;
        tick();
        idle_inputs();
        checkOutput("clr_busy_rise",  32'(busy),     32'd1);
        checkOutput("clr_ready_low",  32'(wr_ready), 32'd0);
        busy_cycles = 1;
        guard = 0;
        while (busy && guard < 40) begin
            lookup_req   = 1'b1;
            lookup_index = 8'h07;
            wr_en        = 1'b1;
            wr_index     = 8'h04;
            wr_data      = 8'h44;
            clr_start    = (guard == 3);
            tick();
            guard++;
            if (busy) busy_cycles++;
            checkOutput("clr_lookup_hit",    32'(lookup_hit),    32'd0);
            checkOutput("clr_lookup_target", 32'(lookup_target), 32'd0);
        end
        idle_inputs();
        checkOutput("clr_busy_cycles", 32'(busy_cycles), 32'd16);
        checkOutput("clr_ready_back",  32'(wr_ready),    32'd1);

        for (int i = 0; i < DEPTH; i++) begin
            lookup_req   = 1'b1;
            lookup_index = 8'(i);
            tick();
            checkOutput($sformatf("post_clr%0d_valid", i), 32'(lookup_valid), 32'd1);
            checkOutput($sformatf("post_clr%0d_hit", i),   32'(lookup_hit),   32'd0);
        end
        idle_inputs();
        tick();

        // Reset partway through a clear must abort it immediately.
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        repeat (4) tick();
        checkOutput("midclr_busy_before", 32'(busy), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("midclr_busy",  32'(busy),         32'd0);
        checkOutput("midclr_ready", 32'(wr_ready),     32'd1);
        checkOutput("midclr_valid", 32'(lookup_valid), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        tick();

        lookup_req   = 1'b1;
        lookup_index = 8'h08;
        tick();
        idle_inputs();
        checkOutput("e8_hit",    32'(lookup_hit),    32'(PL));
        checkOutput("e8_target", 32'(lookup_target), PL ? 32'h7B : 32'h0);

        write_entry(8'h0A, 8'hC3);
        write_entry(8'h20, 8'h5A);

        for (int i = 0; i < 20; i++) begin
            lookup_req   = 1'b1;
            lookup_index = 8'(i);
            tick();
            a = 4'(i);
            checkOutput($sformatf("b2b%0d_valid", i),  32'(lookup_valid),  32'd1);
            checkOutput($sformatf("b2b%0d_hit", i),    32'(lookup_hit),    32'(mv[a]));
            checkOutput($sformatf("b2b%0d_target", i), 32'(lookup_target), 32'(md[a]));
        end
        idle_inputs();
        tick();
        checkOutput("hold_valid",  32'(lookup_valid),  32'd0);
        checkOutput("hold_hit",    32'(lookup_hit),    32'(mv[3]));
        checkOutput("hold_target", 32'(lookup_target), 32'(md[3]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
